rtc_bus_responder: RTL and testbench
====================================

# rtc_bus_responder

Synthesizable responder for the RTC multiplexed address/data bus: the device end of the cycles that the RTC init/read FSMs drive on `a_d`/`cs`/`rd`/`wr`. It decodes address and data phases and holds the RTC register map, with shadow time registers committed by the transfer command and a BCD time base advanced by a 1 Hz tick. It stands in for the RTC chip in simulation and board-level loopback, so the initiator FSMs can be exercised without the physical device.

## Interface
- `TRANSFER_ADDR`, 8'hF0, data write to this address commits the shadow time registers to the live ones.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `a_d`  in  1  phase select: 0 = address phase, 1 = data phase.
- `cs`  in  1  chip select, active-low.
- `rd`  in  1  read strobe, active-low.
- `wr`  in  1  write strobe, active-low.
- `dat_in`  in  8  bus value driven by the initiator.
- `tick_1hz`  in  1  one-cycle pulse; advances the live time.
- `dat_out`  out  8  read data, registered.
- `dat_oe`  out  1  responder drives the bus; registered.

## Operation
- Register map: st2 0x02, seg 0x21, min 0x22, hora 0x23, dia 0x24, mes 0x25, anio 0x26, seg_tim 0x41, min_tim 0x42, hora_tim 0x43, tim_en 0x03, transfer 0xF0.
- Strobe edges: `wr_q`/`rd_q` hold the previous-cycle strobes. Write event = `cs`=0, `wr_q`=0, `wr`=1 (rising `wr`).
- Address phase: write event with `a_d`=0 loads `addr` <= `dat_in`.
- Data write: a write event with `a_d`=1 writes `dat_in` into the register selected by `addr`.
  - seg..anio: written to the shadow copy only.
  - st2, tim_en, timer registers: written directly.
  - `addr`=`TRANSFER_ADDR`: copies all six shadow registers to live, any data value; the commit also clears a pending tick.
  - Unmapped address: ignored.
- Data read: `cs`=0, `a_d`=1, `rd`=0 sampled at a clock edge. On the next edge `dat_oe`=1 and `dat_out`=live[addr].
  - Unmapped address reads 0x00.
  - Reads of seg..anio return the live value, never the shadow.
- Time base, on `tick_1hz` (BCD):
  - seg increments; 0x59 -> 0x00 with carry into min.
  - min increments the same way; 0x59 -> 0x00 with carry into hora.
  - hora: 0x23 -> 0x00; carry is discarded (dia/mes/anio do not advance).
  - Low nibble 9 -> 0 with high nibble +1.
  - Invalid BCD (low nibble > 9, or value above the field maximum): next value 0x00 with carry.
- Simultaneous events:
  - Commit and tick in the same cycle: commit wins and the tick is dropped.
  - Shadow write and tick: both take effect.
  - Data write to a live timer/st2 register is unaffected by the tick.

## Timing
- Reset values: `dat_out`=0x00, `dat_oe`=0, `addr`=0x00, all live and shadow registers 0x00, `wr_q`=`rd_q`=1.
- Write latency: register updated on the edge after the `wr` rising edge is detected, i.e. 2 clocks after `wr` returns high at the input.
- Read latency: 1 clock from sampling `rd`=0 to valid `dat_out`/`dat_oe`. `dat_out` holds while the read condition persists and tracks live updates.
- `dat_oe` deasserts 1 clock after `rd`=1 or `cs`=1 is sampled.
- `dat_out` keeps its last value when `dat_oe`=0.
- Reset asserted mid-cycle: immediate return to the reset values, and the partial cycle is discarded. After release, the first write needs a fresh `wr` low->high.
- A `wr` low pulse with `cs`=1 at the rising edge is ignored.

## Structure
- Shared package `rtc_pkg`:
  - register address constants (the map above plus `TRANSFER_ADDR`);
  - BCD maxima 8'h59 and 8'h23.
- Sub-module `bcd_inc`: inputs value[7:0] and max[7:0]; outputs next[7:0] and carry. Purely combinational, instantiated three times.
- Top contains:
  - the edge-detect registers and address latch;
  - shadow and live register banks;
  - the read mux and output registers.

## Test plan
- Reset release: `dat_oe`=0 and `dat_out`=0x00. Read of 0x21 returns 0x00 one clock after `rd`=0.
- Address 0x22, data 0x59, then read 0x22 before commit: reads 0x00. Write to 0xF0, then read 0x22: reads 0x59.
- Load 0x23/0x59/0x59 into hora/min/seg and commit, then one `tick_1hz` pulse: reads 0x00/0x00/0x00; dia is unchanged.
- Write 0x5A to seg and commit, then tick: seg=0x00 and min increments by 1.
- Commit and `tick_1hz` in the same cycle with shadow seg=0x10: live seg=0x10, not 0x11.
- Write 0xAA to unmapped address 0x50: reads 0x00. Assert reset during the read data phase: `dat_oe` drops immediately and st2 reads 0x00 afterwards.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants for the RTC bus responder: register map and BCD field limits.
package rtc_pkg;

    localparam logic [7:0] ADDR_ST2      = 8'h02;
    localparam logic [7:0] ADDR_TIM_EN   = 8'h03;
    localparam logic [7:0] ADDR_SEG      = 8'h21;
    localparam logic [7:0] ADDR_MIN      = 8'h22;
    localparam logic [7:0] ADDR_HORA     = 8'h23;
    localparam logic [7:0] ADDR_DIA      = 8'h24;
    localparam logic [7:0] ADDR_MES      = 8'h25;
    localparam logic [7:0] ADDR_ANIO     = 8'h26;
    localparam logic [7:0] ADDR_SEG_TIM  = 8'h41;
    localparam logic [7:0] ADDR_MIN_TIM  = 8'h42;
    localparam logic [7:0] ADDR_HORA_TIM = 8'h43;
    localparam logic [7:0] TRANSFER_ADDR = 8'hF0;

    localparam logic [7:0] BCD_MAX_MS    = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR  = 8'h23;

    // Slot numbers of the six time fields inside the live/shadow banks.
    localparam int T_SEG  = 0;
    localparam int T_MIN  = 1;
    localparam int T_HORA = 2;
    localparam int T_DIA  = 3;
    localparam int T_MES  = 4;
    localparam int T_ANIO = 5;
    localparam int N_TIME = 6;

endpackage

// File: rtl/bcd_inc.sv
// Two-digit BCD incrementer with wrap at a field maximum; invalid input wraps to 0x00.
module bcd_inc (
    input  logic [7:0] value,
    input  logic [7:0] max,
    output logic [7:0] next,
    output logic       carry
);

    always_comb begin
        next  = value + 8'd1;
        carry = 1'b0;
        if ((value[3:0] > 4'd9) || (value >= max)) begin
            next  = 8'h00;
            carry = 1'b1;
        end else if (value[3:0] == 4'd9) begin
            next = {value[7:4] + 4'd1, 4'h0};
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// Device side of the RTC multiplexed bus: address latch, register map with
// shadow/live time banks committed through TRANSFER_ADDR, and a BCD 1 Hz time base.
module rtc_bus_responder
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       a_d,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] dat_in,
    input  logic       tick_1hz,
    output logic [7:0] dat_out,
    output logic       dat_oe
);

    // Bus protocol: a write is the rising edge of wr while cs is low; a_d at that
    // edge selects address (0) or data (1) phase. The event is registered and
    // applied one edge later. A read is the level cs=0, a_d=1, rd=0; the responder
    // drives dat_out/dat_oe from the following edge for as long as it persists.
    logic       wr_q, wr_d;
    logic       wr_ev_q, wr_ev_d;
    logic       wr_ad_q, wr_ad_d;
    logic [7:0] wr_dat_q, wr_dat_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] st2_q, st2_d;
    logic [7:0] tim_en_q, tim_en_d;
    logic [7:0] seg_tim_q, seg_tim_d;
    logic [7:0] min_tim_q, min_tim_d;
    logic [7:0] hora_tim_q, hora_tim_d;
    logic [7:0] live_q   [N_TIME];
    logic [7:0] live_d   [N_TIME];
    logic [7:0] shadow_q [N_TIME];
    logic [7:0] shadow_d [N_TIME];
    logic [7:0] dat_out_q, dat_out_d;
    logic       dat_oe_q, dat_oe_d;

    logic       data_we, commit, rd_cond;
    logic [7:0] rd_data;
    logic [7:0] seg_nx, min_nx, hora_nx;
    logic       seg_c, min_c, hora_c;

    bcd_inc u_inc_seg (
        .value (live_q[T_SEG]),
        .max   (BCD_MAX_MS),
        .next  (seg_nx),
        .carry (seg_c)
    );

    bcd_inc u_inc_min (
        .value (live_q[T_MIN]),
        .max   (BCD_MAX_MS),
        .next  (min_nx),
        .carry (min_c)
    );

    bcd_inc u_inc_hora (
        .value (live_q[T_HORA]),
        .max   (BCD_MAX_HOUR),
        .next  (hora_nx),
        .carry (hora_c)
    );

    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            ADDR_ST2:      rd_data = st2_q;
            ADDR_TIM_EN:   rd_data = tim_en_q;
            ADDR_SEG:      rd_data = live_q[T_SEG];
            ADDR_MIN:      rd_data = live_q[T_MIN];
            ADDR_HORA:     rd_data = live_q[T_HORA];
            ADDR_DIA:      rd_data = live_q[T_DIA];
            ADDR_MES:      rd_data = live_q[T_MES];
            ADDR_ANIO:     rd_data = live_q[T_ANIO];
            ADDR_SEG_TIM:  rd_data = seg_tim_q;
            ADDR_MIN_TIM:  rd_data = min_tim_q;
            ADDR_HORA_TIM: rd_data = hora_tim_q;
            default:       rd_data = 8'h00;
        endcase
    end

    always_comb begin
        wr_d       = wr;
        wr_ev_d    = !cs && !wr_q && wr;
        wr_ad_d    = a_d;
        wr_dat_d   = dat_in;
        addr_d     = addr_q;
        st2_d      = st2_q;
        tim_en_d   = tim_en_q;
        seg_tim_d  = seg_tim_q;
        min_tim_d  = min_tim_q;
        hora_tim_d = hora_tim_q;
        for (int i = 0; i < N_TIME; i++) begin
            live_d[i]   = live_q[i];
            shadow_d[i] = shadow_q[i];
        end

        data_we = wr_ev_q && wr_ad_q;
        commit  = data_we && (addr_q == TRANSFER_ADDR);

        if (wr_ev_q && !wr_ad_q) begin
            addr_d = wr_dat_q;
        end

        if (data_we) begin
            case (addr_q)
                ADDR_ST2:      st2_d            = wr_dat_q;
                ADDR_TIM_EN:   tim_en_d         = wr_dat_q;
                ADDR_SEG_TIM:  seg_tim_d        = wr_dat_q;
                ADDR_MIN_TIM:  min_tim_d        = wr_dat_q;
                ADDR_HORA_TIM: hora_tim_d       = wr_dat_q;
                ADDR_SEG:      shadow_d[T_SEG]  = wr_dat_q;
                ADDR_MIN:      shadow_d[T_MIN]  = wr_dat_q;
                ADDR_HORA:     shadow_d[T_HORA] = wr_dat_q;
                ADDR_DIA:      shadow_d[T_DIA]  = wr_dat_q;
                ADDR_MES:      shadow_d[T_MES]  = wr_dat_q;
                ADDR_ANIO:     shadow_d[T_ANIO] = wr_dat_q;
                default:       ;
            endcase
        end

        // Commit overrides a coincident tick, so a freshly set time is never bumped.
        if (commit) begin
            for (int i = 0; i < N_TIME; i++) begin
                live_d[i] = shadow_q[i];
            end
        end else if (tick_1hz) begin
            live_d[T_SEG] = seg_nx;
            if (seg_c) begin
                live_d[T_MIN] = min_nx;
                // The hour carry stops here: day/month/year never advance.
                if (min_c) begin
                    live_d[T_HORA] = hora_c ? 8'h00 : hora_nx;
                end
            end
        end

        rd_cond   = !cs && a_d && !rd;
        dat_oe_d  = rd_cond;
        dat_out_d = rd_cond ? rd_data : dat_out_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q       <= 1'b1;
            wr_ev_q    <= 1'b0;
            wr_ad_q    <= 1'b0;
            wr_dat_q   <= 8'h00;
            addr_q     <= 8'h00;
            st2_q      <= 8'h00;
            tim_en_q   <= 8'h00;
            seg_tim_q  <= 8'h00;
            min_tim_q  <= 8'h00;
            hora_tim_q <= 8'h00;
            for (int i = 0; i < N_TIME; i++) begin
                live_q[i]   <= 8'h00;
                shadow_q[i] <= 8'h00;
            end
            dat_out_q  <= 8'h00;
            dat_oe_q   <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            wr_ev_q    <= wr_ev_d;
            wr_ad_q    <= wr_ad_d;
            wr_dat_q   <= wr_dat_d;
            addr_q     <= addr_d;
            st2_q      <= st2_d;
            tim_en_q   <= tim_en_d;
            seg_tim_q  <= seg_tim_d;
            min_tim_q  <= min_tim_d;
            hora_tim_q <= hora_tim_d;
            for (int i = 0; i < N_TIME; i++) begin
                live_q[i]   <= live_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            dat_out_q  <= dat_out_d;
            dat_oe_q   <= dat_oe_d;
        end
    end

    assign dat_out = dat_out_q;
    assign dat_oe  = dat_oe_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Self-checking bench for rtc_bus_responder: bus write/read drivers, a read-data
// scoreboard queue, and one task per feature.
module tb_rtc_bus_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a_d = 1'b0;
    logic       cs = 1'b1;
    logic       rd = 1'b1;
    logic       wr = 1'b1;
    logic [7:0] dat_in = 8'h00;
    logic       tick_1hz = 1'b0;
    logic [7:0] dat_out;
    logic       dat_oe;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         errors = 0;
    int         checks = 0;

    rtc_bus_responder dut (
        .clk      (clk),
        .reset    (reset),
        .a_d      (a_d),
        .cs       (cs),
        .rd       (rd),
        .wr       (wr),
        .dat_in   (dat_in),
        .tick_1hz (tick_1hz),
        .dat_out  (dat_out),
        .dat_oe   (dat_oe)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- drivers ----------------
    // One bus write cycle; the register is updated by the time this returns.
    task automatic bus_write(input logic phase, input logic [7:0] data, input bit tick_on_apply);
        @(negedge clk);
        rd = 1'b1; cs = 1'b0; a_d = phase; dat_in = data; wr = 1'b0;
        @(negedge clk);
        wr = 1'b1;
        @(negedge clk);
        cs = 1'b1; tick_1hz = tick_on_apply;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
        bus_write(1'b0, addr, 1'b0);
        bus_write(1'b1, data, 1'b0);
    endtask

    task automatic commit_shadow();
        write_reg(8'hF0, 8'($urandom_range(0, 255)));
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    // Latches the address, starts a read and queues the expected data. Returns
    // at the negedge following the sampling edge, where dat_out is valid.
    task automatic issue_read(input logic [7:0] addr, input logic [7:0] expected);
        bus_write(1'b0, addr, 1'b0);
        @(negedge clk);
        cs = 1'b0; a_d = 1'b1; rd = 1'b0;
        exp_q.push_back(expected);
        @(negedge clk);
    endtask

    task automatic end_read();
        rd = 1'b1; cs = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [7:0] bcd_next(input logic [7:0] v);
        int b;
        b = int'(v[7:4]) * 10 + int'(v[3:0]) + 1;
        if (b >= 60) b = 0;
        return 8'(((b / 10) << 4) | (b % 10));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dat_oe !== 1'b0) begin
            errors++; $display("FAIL reset_oe: got %b expected 0", dat_oe);
        end
        checks++;
        if (dat_out !== 8'h00) begin
            errors++; $display("FAIL reset_dat_out: got %h expected 00", dat_out);
        end
        issue_read(8'h21, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_oe !== 1'b1 || dat_out !== exp_b) begin
            errors++; $display("FAIL reset_read_seg: got oe=%b data=%h expected oe=1 data=%h", dat_oe, dat_out, exp_b);
        end
        end_read();
        checks++;
        if (dat_oe !== 1'b0) begin
            errors++; $display("FAIL oe_release: got %b expected 0", dat_oe);
        end
    endtask

    task automatic test_shadow_commit();
        write_reg(8'h22, 8'h59);
        issue_read(8'h22, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_oe !== 1'b1 || dat_out !== exp_b) begin
            errors++; $display("FAIL min_before_commit: got oe=%b data=%h expected oe=1 data=%h", dat_oe, dat_out, exp_b);
        end
        end_read();
        commit_shadow();
        issue_read(8'h22, 8'h59);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_oe !== 1'b1 || dat_out !== exp_b) begin
            errors++; $display("FAIL min_after_commit: got oe=%b data=%h expected oe=1 data=%h", dat_oe, dat_out, exp_b);
        end
        end_read();
    endtask

    task automatic test_rollover();
        logic [7:0] addrs [4];
        logic [7:0] exps  [4];
        addrs = '{8'h23, 8'h22, 8'h21, 8'h24};
        exps  = '{8'h00, 8'h00, 8'h00, 8'h15};
        write_reg(8'h23, 8'h23);
        write_reg(8'h22, 8'h59);
        write_reg(8'h21, 8'h59);
        write_reg(8'h24, 8'h15);
        commit_shadow();
        pulse_tick();
        for (int i = 0; i < 4; i++) begin
            issue_read(addrs[i], exps[i]);
            exp_b = exp_q.pop_front();
            checks++;
            if (dat_oe !== 1'b1 || dat_out !== exp_b) begin
                errors++; $display("FAIL rollover_%h: got oe=%b data=%h expected oe=1 data=%h", addrs[i], dat_oe, dat_out, exp_b);
            end
            end_read();
        end
    endtask

    task automatic test_invalid_bcd();
        write_reg(8'h22, 8'h12);
        write_reg(8'h21, 8'h5A);
        commit_shadow();
        pulse_tick();
        issue_read(8'h21, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL invalid_seg: got %h expected %h", dat_out, exp_b);
        end
        end_read();
        issue_read(8'h22, 8'h13);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL invalid_seg_carry_min: got %h expected %h", dat_out, exp_b);
        end
        end_read();
        // Out-of-range hour wraps to 00 on the incoming carry.
        write_reg(8'h23, 8'h24);
        write_reg(8'h22, 8'h59);
        write_reg(8'h21, 8'h59);
        commit_shadow();
        pulse_tick();
        issue_read(8'h23, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL invalid_hora: got %h expected %h", dat_out, exp_b);
        end
        end_read();
    endtask

    task automatic test_bcd_digits();
        logic [7:0] v;
        int b;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                v = 8'h09;
            end else begin
                b = $urandom_range(0, 59);
                v = 8'(((b / 10) << 4) | (b % 10));
            end
            write_reg(8'h21, v);
            commit_shadow();
            pulse_tick();
            issue_read(8'h21, bcd_next(v));
            exp_b = exp_q.pop_front();
            checks++;
            if (dat_out !== exp_b) begin
                errors++; $display("FAIL seg_step_from_%h: got %h expected %h", v, dat_out, exp_b);
            end
            end_read();
        end
    endtask

    task automatic test_commit_tick();
        write_reg(8'h21, 8'h10);
        bus_write(1'b0, 8'hF0, 1'b0);
        bus_write(1'b1, 8'h00, 1'b1);
        issue_read(8'h21, 8'h10);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL commit_beats_tick: got %h expected %h", dat_out, exp_b);
        end
        end_read();
        // Shadow write and tick in the same cycle both land.
        bus_write(1'b0, 8'h21, 1'b0);
        bus_write(1'b1, 8'h30, 1'b1);
        issue_read(8'h21, 8'h11);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL shadow_write_tick_live: got %h expected %h", dat_out, exp_b);
        end
        end_read();
        commit_shadow();
        issue_read(8'h21, 8'h30);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL shadow_write_tick_commit: got %h expected %h", dat_out, exp_b);
        end
        end_read();
    endtask

    task automatic test_direct_regs();
        bus_write(1'b0, 8'h41, 1'b0);
        bus_write(1'b1, 8'h12, 1'b1);
        write_reg(8'h03, 8'h01);
        issue_read(8'h41, 8'h12);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL seg_tim_with_tick: got %h expected %h", dat_out, exp_b);
        end
        end_read();
        issue_read(8'h03, 8'h01);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL tim_en: got %h expected %h", dat_out, exp_b);
        end
        end_read();
    endtask

    task automatic test_unmapped_and_cs();
        write_reg(8'h50, 8'hAA);
        issue_read(8'h50, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_oe !== 1'b1 || dat_out !== exp_b) begin
            errors++; $display("FAIL unmapped_read: got oe=%b data=%h expected oe=1 data=%h", dat_oe, dat_out, exp_b);
        end
        end_read();
        // wr pulse with cs high must not write st2.
        bus_write(1'b0, 8'h02, 1'b0);
        @(negedge clk);
        cs = 1'b1; a_d = 1'b1; dat_in = 8'h33; wr = 1'b0;
        @(negedge clk);
        wr = 1'b1;
        repeat (2) @(negedge clk);
        issue_read(8'h02, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL cs_high_write: got %h expected %h", dat_out, exp_b);
        end
        end_read();
    endtask

    task automatic test_reset_mid_read();
        write_reg(8'h02, 8'h77);
        issue_read(8'h02, 8'h77);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_oe !== 1'b1 || dat_out !== exp_b) begin
            errors++; $display("FAIL st2_before_reset: got oe=%b data=%h expected oe=1 data=%h", dat_oe, dat_out, exp_b);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dat_oe !== 1'b0 || dat_out !== 8'h00) begin
            errors++; $display("FAIL reset_mid_read: got oe=%b data=%h expected oe=0 data=00", dat_oe, dat_out);
        end
        rd = 1'b1; cs = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        issue_read(8'h02, 8'h00);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL st2_after_reset: got %h expected %h", dat_out, exp_b);
        end
        end_read();
        write_reg(8'h42, 8'h45);
        issue_read(8'h42, 8'h45);
        exp_b = exp_q.pop_front();
        checks++;
        if (dat_out !== exp_b) begin
            errors++; $display("FAIL write_after_reset: got %h expected %h", dat_out, exp_b);
        end
        end_read();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_shadow_commit();
        test_rollover();
        test_invalid_bcd();
        test_bcd_digits();
        test_commit_tick();
        test_direct_regs();
        test_unmapped_and_cs();
        test_reset_mid_read();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
